// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit: multi-cycle unsigned multiply/divide unit for the 16-bit core.
// It latches the operands on start and iterates one bit per cycle: shift-add for
// multiply, restoring division for divide. It then writes the selected half of the
// result back through a single-cycle register file write.
module iter_muldiv_unit #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [REG_AW-1:0] dest_reg,
  output logic              busy,
  output logic              done,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [WIDTH-1:0]  wb_data,
  output logic              div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  // hi holds the upper product half (multiply) or the partial remainder (divide);
  // lo holds the multiplier being shifted out, or the dividend becoming the quotient.
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_reg_q, wb_reg_d;
  logic [WIDTH-1:0]  wb_data_q, wb_data_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic              div_ge;
  logic [WIDTH-1:0]  div_diff;
  logic [WIDTH-1:0]  step_hi;
  logic [WIDTH-1:0]  step_lo;

  // One iteration of the datapath: shift-add multiply or restoring-divide step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opa_q : {WIDTH{1'b0}})};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    if (op_q[1]) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state and next-output logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    dest_d    = dest_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    dbz_d     = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = op;
          opa_d   = operand_a;
          opb_d   = operand_b;
          dest_d  = dest_reg;
          hi_d    = '0;
          lo_d    = op[1] ? operand_a : operand_b;
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          wb_en_d   = (dest_q != '0);
          wb_reg_d  = dest_q;
          wb_data_d = op_q[0] ? step_hi : step_lo;
          dbz_d     = op_q[1] && (opb_q == '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      dest_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      dest_q    <= dest_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wb_en       = wb_en_q;
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed testbench for iter_muldiv_unit with hand-computed expected results.
module tb_iter_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  dest_reg;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        div_by_zero;

  int checks;
  int errors;

  iter_muldiv_unit #(.WIDTH(16), .REG_AW(3)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .dest_reg(dest_reg),
    .busy(busy),
    .done(done),
    .wb_en(wb_en),
    .wb_reg(wb_reg),
    .wb_data(wb_data),
    .div_by_zero(div_by_zero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start pulse; returns at the negedge just after the sampling edge.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; dest_reg = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one operation and capture what the unit shows at each point of its timeline.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d, output logic early, output logic [15:0] data,
                        output logic [2:0] wreg, output logic en, output logic dn,
                        output logic dbz, output logic busy_after, output logic tail);
    issue(o, a, b, d);
    early = (!busy || done || wb_en || div_by_zero);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (!busy || done || wb_en || div_by_zero) early = 1'b1;
    end
    @(negedge clk);
    data = wb_data; wreg = wb_reg; en = wb_en; dn = done; dbz = div_by_zero;
    if (!busy) early = 1'b1;
    @(negedge clk);
    busy_after = busy;
    tail = done | wb_en | div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 2'b00; operand_a = 16'h1111; operand_b = 16'h2222;
    dest_reg = 3'd1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (wb_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_en: got %b want 0", wb_en); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b want 0", div_by_zero); end
    checks++; if (wb_reg !== 3'd0) begin errors++; $display("[TB] FAIL reset_wb_reg: got %0d want 0", wb_reg); end
    checks++; if (wb_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wb_data: got %h want 0000", wb_data); end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_after: got busy %b want 0", busy); end
  endtask

  task automatic test_mul_basic();
    logic early, en, dn, dbz, ba, tail;
    logic [15:0] data;
    logic [2:0] wreg;
    run_op(2'b00, 16'h1234, 16'h0010, 3'd3, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL mullo_timing: early/gap flag %b want 0", early); end
    checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL mullo_done: got %b want 1", dn); end
    checks++; if (en !== 1'b1) begin errors++; $display("[TB] FAIL mullo_wb_en: got %b want 1", en); end
    checks++; if (wreg !== 3'd3) begin errors++; $display("[TB] FAIL mullo_wb_reg: got %0d want 3", wreg); end
    checks++; if (data !== 16'h2340) begin errors++; $display("[TB] FAIL mullo_data: got %h want 2340", data); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("[TB] FAIL mullo_dbz: got %b want 0", dbz); end
    checks++; if (ba !== 1'b0 || tail !== 1'b0) begin errors++; $display("[TB] FAIL mullo_idle: busy %b pulses %b want 0 0", ba, tail); end
    run_op(2'b01, 16'h1234, 16'h0010, 3'd3, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL mulhi_timing: early/gap flag %b want 0", early); end
    checks++; if (data !== 16'h0001) begin errors++; $display("[TB] FAIL mulhi_data: got %h want 0001", data); end
  endtask

  task automatic test_mul_max();
    logic early, en, dn, dbz, ba, tail;
    logic [15:0] data;
    logic [2:0] wreg;
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 3'd5, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (data !== 16'hFFFE) begin errors++; $display("[TB] FAIL mulhi_max_data: got %h want fffe", data); end
    checks++; if (wreg !== 3'd5) begin errors++; $display("[TB] FAIL mulhi_max_reg: got %0d want 5", wreg); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("[TB] FAIL mulhi_max_dbz: got %b want 0", dbz); end
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 3'd5, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (data !== 16'h0001) begin errors++; $display("[TB] FAIL mullo_max_data: got %h want 0001", data); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("[TB] FAIL mullo_max_dbz: got %b want 0", dbz); end
  endtask

  task automatic test_divide();
    logic early, en, dn, dbz, ba, tail;
    logic [15:0] data;
    logic [2:0] wreg;
    run_op(2'b10, 16'd100, 16'd7, 3'd2, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL divq_timing: early/gap flag %b want 0", early); end
    checks++; if (data !== 16'h000E) begin errors++; $display("[TB] FAIL divq_100_7: got %h want 000e", data); end
    checks++; if (en !== 1'b1 || wreg !== 3'd2) begin errors++; $display("[TB] FAIL divq_wb: got en %b reg %0d want 1 2", en, wreg); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("[TB] FAIL divq_dbz: got %b want 0", dbz); end
    run_op(2'b11, 16'd100, 16'd7, 3'd2, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (data !== 16'h0002) begin errors++; $display("[TB] FAIL divr_100_7: got %h want 0002", data); end
    run_op(2'b10, 16'd5, 16'd9, 3'd2, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (data !== 16'h0000) begin errors++; $display("[TB] FAIL divq_5_9: got %h want 0000", data); end
    run_op(2'b11, 16'd5, 16'd9, 3'd2, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (data !== 16'h0005) begin errors++; $display("[TB] FAIL divr_5_9: got %h want 0005", data); end
  endtask

  task automatic test_div_by_zero();
    logic early, en, dn, dbz, ba, tail;
    logic [15:0] data;
    logic [2:0] wreg;
    run_op(2'b10, 16'h00AB, 16'h0000, 3'd6, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL dbz_q_timing: early/gap flag %b want 0", early); end
    checks++; if (data !== 16'hFFFF) begin errors++; $display("[TB] FAIL dbz_q_data: got %h want ffff", data); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("[TB] FAIL dbz_q_flag: got %b want 1", dbz); end
    checks++; if (tail !== 1'b0) begin errors++; $display("[TB] FAIL dbz_q_one_cycle: pulses after done %b want 0", tail); end
    run_op(2'b11, 16'h00AB, 16'h0000, 3'd6, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (data !== 16'h00AB) begin errors++; $display("[TB] FAIL dbz_r_data: got %h want 00ab", data); end
    checks++; if (dbz !== 1'b1 || tail !== 1'b0) begin errors++; $display("[TB] FAIL dbz_r_flag: got %b tail %b want 1 0", dbz, tail); end
  endtask

  task automatic test_back_to_back();
    logic gap;
    int   done_cnt;
    logic early, en, dn, dbz, ba, tail;
    logic [15:0] data;
    logic [2:0] wreg;
    gap = 1'b0;
    done_cnt = 0;
    issue(2'b00, 16'd3, 16'd5, 3'd4);
    if (!busy) gap = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (!busy) gap = 1'b1;
      if (done) done_cnt++;
      if (i == 16) begin
        checks++; if (done !== 1'b1 || wb_en !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done: got done %b en %b want 1 1", done, wb_en); end
        checks++; if (wb_data !== 16'h000F || wb_reg !== 3'd4) begin errors++; $display("[TB] FAIL b2b_result: got %h reg %0d want 000f reg 4", wb_data, wb_reg); end
      end
      op = 2'(i); operand_a = 16'hA5A5 ^ 16'(i * 16'h0101); operand_b = ~operand_a;
      dest_reg = 3'(i);
      start = (i == 2 || i == 16);
    end
    @(negedge clk);
    start = 1'b0;
    if (done) done_cnt++;
    checks++; if (gap !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_continuous: gap %b want 0", gap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start_not_queued: got busy %b want 0", busy); end
    repeat (3) @(negedge clk);
    if (done) done_cnt++;
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL b2b_single_result: got %0d done pulses want 1", done_cnt); end
    run_op(2'b00, 16'd2, 16'd3, 3'd1, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (early !== 1'b0 || data !== 16'h0006) begin errors++; $display("[TB] FAIL b2b_next_start: got %h early %b want 0006 0", data, early); end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    logic early, en, dn, dbz, ba, tail;
    logic [15:0] data;
    logic [2:0] wreg;
    seen = 1'b0;
    issue(2'b00, 16'h1234, 16'h0010, 3'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (wb_en || done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_wb: activity %b want 0", seen); end
    run_op(2'b00, 16'd2, 16'd3, 3'd0, early, data, wreg, en, dn, dbz, ba, tail);
    checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL dest0_done: got %b want 1", dn); end
    checks++; if (en !== 1'b0) begin errors++; $display("[TB] FAIL dest0_wb_en: got %b want 0", en); end
    checks++; if (early !== 1'b0 || tail !== 1'b0) begin errors++; $display("[TB] FAIL dest0_timing: early %b tail %b want 0 0", early, tail); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_divide();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_muldiv_unit.md
Name: iter_muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide unit for the 16-bit core. It sits between the register file read ports (operands) and its write port (result).
- Operands and destination are latched on a start pulse. The unit iterates one bit per cycle and then drives a single-cycle writeback (wb_en/wb_reg/wb_data) straight into the register file write port.
- busy lets the control path stall the PC while the operation runs.

Parameters:
- WIDTH, 16, operand/result width in bits; iteration count equals WIDTH.
- REG_AW, 3, destination register address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MULLO (low half of product), 01 MULHI (high half), 10 DIVQ (quotient), 11 DIVR (remainder).
- operand_a  input  WIDTH  multiplicand/dividend (register file read data 1).
- operand_b  input  WIDTH  multiplier/divisor (register file read data 2).
- dest_reg  input  REG_AW  destination register address.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- wb_en  output  1  register file write enable.
- wb_reg  output  REG_AW  register file write address.
- wb_data  output  WIDTH  register file write data.
- div_by_zero  output  1  valid with done; high if a DIVQ/DIVR had operand_b==0.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - State goes to IDLE.
  - busy, done, wb_en, div_by_zero, wb_reg and wb_data are all 0.
  - Iteration counter and internal registers are cleared.
  - rst has priority over start.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge latches op, operand_a, operand_b and dest_reg, clears the counter, and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Exactly WIDTH cycles, counter 0..WIDTH-1. One iteration per cycle.
  - Moves to DONE on the edge where the counter equals WIDTH-1.
  - Input changes during RUN have no effect. start is ignored in RUN and DONE; it is not queued.
- DONE:
  - Exactly one cycle with done=1. Then returns to IDLE.
  - wb_en=1 unless the latched dest_reg==0, in which case wb_en=0 and done still pulses.
- Outside DONE: wb_en=0 and done=0. wb_reg and wb_data hold their last values but are meaningful only while wb_en=1.
- Latency and throughput:
  - start sampled at edge N -> busy from cycle N+1.
  - done/wb_en in cycle N+1+WIDTH (cycle N+17 for WIDTH=16).
  - IDLE again at N+WIDTH+2. Minimum start-to-start spacing is WIDTH+2 cycles.
- Multiply: unsigned shift-add into a 2*WIDTH product register.
  - MULLO returns product[WIDTH-1:0]; MULHI returns product[2*WIDTH-1:WIDTH].
  - No overflow flag.
- Divide: unsigned restoring division, one quotient bit per cycle, MSB first. DIVQ returns the quotient; DIVR returns the remainder.
- Divide by zero (operand_b==0 with op 10/11):
  - Runs the full WIDTH cycles.
  - Result is quotient all-ones (16'hFFFF) and remainder = dividend.
  - div_by_zero=1 during DONE only.
  - Never asserted for multiply ops.
- Reset mid-operation: any rst in RUN or DONE aborts immediately. No writeback occurs and the latched operation is discarded.
- Output registers: all outputs are driven from registers (no combinational path from inputs to outputs).

Test Plan:
- Reset then op=00, a=16'h1234, b=16'h0010, dest=3 -> done and wb_en exactly 17 cycles after start, wb_reg=3, wb_data=16'h2340. Repeat with op=01 -> wb_data=16'h0001.
- op=01 and op=00 with a=b=16'hFFFF, dest=5 -> MULHI wb_data=16'hFFFE, MULLO wb_data=16'h0001, div_by_zero=0.
- op=10/11, a=100, b=7, dest=2 -> quotient 14 (16'h000E), remainder 2. Then a=5, b=9 -> quotient 0, remainder 5.
- op=10/11, a=16'h00AB, b=0 -> wb_data 16'hFFFF and 16'h00AB respectively, div_by_zero=1 for exactly one cycle.
- Start pulsed again at cycles 3 and 17 after the first start, with operands toggled during RUN -> single result from the first operands only, busy continuous, next start accepted only once back in IDLE.
- rst asserted on RUN cycle 8 -> next cycle busy=0, no wb_en pulse ever appears. dest=0 run -> done pulses, wb_en stays 0.
